// File: rtl/potential_state_sequencer.sv
// Membrane-potential store and sequencer feeding the per-neuron potential adder.
// Optional spike_count output is enabled with `define SPIKE_COUNT_EN.
module potential_state_sequencer #(
  parameter int NUM_NEURONS = 30,
  parameter int IDX_W       = 5,
  parameter int DECAY_SHIFT = 1,
  parameter int ADDER_LAT   = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   timestep_start,
  input  logic                   weight_valid,
  input  logic [31:0]            weight_in,
  output logic                   weight_ready,
  output logic                   set_adder,
  output logic                   clear_adder,
  output logic [31:0]            input_weight_out,
  output logic [31:0]            decayed_potential_out,
  input  logic [31:0]            final_potential_in,
  input  logic                   spike_in,
  output logic [IDX_W-1:0]       neuron_index,
  output logic [NUM_NEURONS-1:0] spike_vector,
  output logic                   busy,
`ifdef SPIKE_COUNT_EN
  output logic [IDX_W:0]         spike_count,
`endif
  output logic                   done
);

  localparam int CNT_W = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
  localparam int SC_W  = IDX_W + 1;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_FETCH, S_WAIT, S_CAPTURE} state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [31:0]            v_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] shadow_q;
  logic [NUM_NEURONS-1:0] shadow_d;
  logic [NUM_NEURONS-1:0] spikeVec_q;
  logic                   weightReady_q;
  logic                   setAdder_q;
  logic                   clearAdder_q;
  logic [31:0]            inWeight_q;
  logic [31:0]            decayed_q;
  logic                   busy_q;
  logic                   done_q;
  logic [CNT_W-1:0]       waitCnt_q;
  logic [IDX_W-1:0]       idxNext;
  logic [31:0]            nextV;
  logic                   isLast;
  logic [SC_W-1:0]        spikeCount_q;

  // Halving by exponent decrement; values that would go subnormal flush to +0.
  function automatic logic [31:0] decay(input logic [31:0] x);
    logic [7:0] e;
    e = x[30:23];
    if (e == 8'hFF)
      decay = x;
    else if (e <= 8'(DECAY_SHIFT))
      decay = 32'h0000_0000;
    else
      decay = {x[31], e - 8'(DECAY_SHIFT), x[22:0]};
  endfunction

  assign idxNext = idx_q + IDX_W'(1);
  assign isLast  = (idx_q == IDX_W'(NUM_NEURONS - 1));

  always_comb begin
    nextV    = 32'h0000_0000;
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (idx_q == IDX_W'(i)) shadow_d[i] = spike_in;
      if (idxNext == IDX_W'(i)) nextV = v_q[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_INIT;
      idx_q         <= '0;
      shadow_q      <= '0;
      spikeVec_q    <= '0;
      weightReady_q <= 1'b0;
      setAdder_q    <= 1'b0;
      clearAdder_q  <= 1'b1;
      inWeight_q    <= '0;
      decayed_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      waitCnt_q     <= '0;
      spikeCount_q  <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) v_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          setAdder_q   <= 1'b1;
          clearAdder_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        S_IDLE: begin
          setAdder_q   <= 1'b0;
          clearAdder_q <= 1'b1;
          if (timestep_start) begin
            clearAdder_q  <= 1'b0;
            idx_q         <= '0;
            busy_q        <= 1'b1;
            weightReady_q <= 1'b1;
            decayed_q     <= decay(v_q[0]);
            state_q       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (weight_valid) begin
            inWeight_q    <= weight_in;
            weightReady_q <= 1'b0;
            waitCnt_q     <= '0;
            state_q       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (waitCnt_q == CNT_W'(ADDER_LAT - 1))
            state_q <= S_CAPTURE;
          else
            waitCnt_q <= waitCnt_q + CNT_W'(1);
        end
        S_CAPTURE: begin
          shadow_q <= shadow_d;
          for (int i = 0; i < NUM_NEURONS; i++)
            if (idx_q == IDX_W'(i)) v_q[i] <= final_potential_in;
          if (isLast) begin
            spikeVec_q   <= shadow_d;
            spikeCount_q <= SC_W'($countones(shadow_d));
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            clearAdder_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            idx_q         <= idxNext;
            decayed_q     <= decay(nextV);
            weightReady_q <= 1'b1;
            state_q       <= S_FETCH;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign weight_ready          = weightReady_q;
  assign set_adder             = setAdder_q;
  assign clear_adder           = clearAdder_q;
  assign input_weight_out      = inWeight_q;
  assign decayed_potential_out = decayed_q;
  assign neuron_index          = idx_q;
  assign spike_vector          = spikeVec_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
`ifdef SPIKE_COUNT_EN
  assign spike_count           = spikeCount_q;
`endif

endmodule

// File: tb/tb_potential_state_sequencer.sv
// Directed bench for potential_state_sequencer: a 1-neuron instance for the
// FP32 decay/latency cases and a 30-neuron instance for full-pass behaviour.
module tb_potential_state_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  // Single-neuron instance
  logic        RST_N1, start1, wv1, spk1;
  logic [31:0] w1, fin1;
  logic        ready1, set1, clr1, busy1, done1;
  logic [31:0] iw1, dec1;
  logic [0:0]  idx1;
  logic [0:0]  sv1;
`ifdef SPIKE_COUNT_EN
  logic [1:0]  sc1;
`endif

  potential_state_sequencer #(
    .NUM_NEURONS(1), .IDX_W(1), .DECAY_SHIFT(1), .ADDER_LAT(1)
  ) dut1 (
    .CLK(CLK), .RST_N(RST_N1), .timestep_start(start1),
    .weight_valid(wv1), .weight_in(w1), .weight_ready(ready1),
    .set_adder(set1), .clear_adder(clr1),
    .input_weight_out(iw1), .decayed_potential_out(dec1),
    .final_potential_in(fin1), .spike_in(spk1),
    .neuron_index(idx1), .spike_vector(sv1), .busy(busy1),
`ifdef SPIKE_COUNT_EN
    .spike_count(sc1),
`endif
    .done(done1)
  );

  // Thirty-neuron instance with an adder model keyed on neuron_index
  logic        RST_N30, start30, wv30, spk30;
  logic [31:0] w30, fin30;
  logic        ready30, set30, clr30, busy30, done30;
  logic [31:0] iw30, dec30;
  logic [4:0]  idx30;
  logic [29:0] sv30;
`ifdef SPIKE_COUNT_EN
  logic [5:0]  sc30;
`endif

  assign fin30 = (idx30 == 5'd0) ? 32'h0080_0000 : 32'h3F80_0000;
  assign spk30 = ~idx30[0];

  potential_state_sequencer #(
    .NUM_NEURONS(30), .IDX_W(5), .DECAY_SHIFT(1), .ADDER_LAT(1)
  ) dut30 (
    .CLK(CLK), .RST_N(RST_N30), .timestep_start(start30),
    .weight_valid(wv30), .weight_in(w30), .weight_ready(ready30),
    .set_adder(set30), .clear_adder(clr30),
    .input_weight_out(iw30), .decayed_potential_out(dec30),
    .final_potential_in(fin30), .spike_in(spk30),
    .neuron_index(idx30), .spike_vector(sv30), .busy(busy30),
`ifdef SPIKE_COUNT_EN
    .spike_count(sc30),
`endif
    .done(done30)
  );

  typedef struct {
    logic        start;
    logic        wv;
    logic [31:0] w;
    logic [31:0] fin;
    logic        spk;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] dec;
    logic [31:0] iw;
    logic        sv;
  } vec_t;

  vec_t vecs[10];

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive the single-neuron inputs from one table record
  task automatic applyStimulus(input vec_t v);
    start1 = v.start;
    wv1    = v.wv;
    w1     = v.w;
    fin1   = v.fin;
    spk1   = v.spk;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int cnt;

    // start, wv, weight, adder final, adder spike | ready, busy, done, decayed, in weight, spike_vector
    vecs[0] = '{1'b1, 1'b1, 32'h42470A3D, 32'h411C28F6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h42470A3D, 32'h411C28F6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h42470A3D, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h42470A3D, 32'h411C28F6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h42470A3D, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h42470A3D, 32'h411C28F6, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h42470A3D, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'h12345678, 32'h411C28F6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h42470A3D, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h00000000, 32'h409C28F6, 1'b0, 1'b1, 1'b1, 1'b0, 32'h409C28F6, 32'h42470A3D, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 32'h00000000, 32'h409C28F6, 1'b0, 1'b0, 1'b1, 1'b0, 32'h409C28F6, 32'h00000000, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 32'h00000000, 32'h409C28F6, 1'b0, 1'b0, 1'b1, 1'b0, 32'h409C28F6, 32'h00000000, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 32'h00000000, 32'h409C28F6, 1'b0, 1'b0, 1'b0, 1'b1, 32'h409C28F6, 32'h00000000, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 32'h00000000, 32'h409C28F6, 1'b0, 1'b0, 1'b0, 1'b0, 32'h409C28F6, 32'h00000000, 1'b0};

    RST_N1 = 1'b0; start1 = 1'b0; wv1 = 1'b0; w1 = '0; fin1 = '0; spk1 = 1'b0;
    RST_N30 = 1'b0; start30 = 1'b0; wv30 = 1'b0; w30 = 32'h3F00_0000;

    // Reset values while held in reset
    tick();
    tick();
    checkOutput("rstCtrl1", {set1, clr1, ready1, busy1, done1, sv1, idx1}, 7'b0100000);
    checkOutput("rstData1", {dec1, iw1}, 64'h0);
    checkOutput("rstCtrl30", {set30, clr30, ready30, busy30, done30, sv30, idx30}, {5'b01000, 30'h0, 5'd0});

    // INIT pulses set_adder for exactly one cycle after release
    RST_N1 = 1'b1;
    RST_N30 = 1'b1;
    tick();
    checkOutput("initSet1", {set1, clr1}, 2'b10);
    tick();
    checkOutput("idleCtrl1", {set1, clr1, busy1, sv1}, 4'b0100);
    checkOutput("idleCtrl30", {set30, clr30, busy30}, 3'b010);

    // Two single-neuron timesteps from the table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vecCtrl%0d", i), {ready1, busy1, done1, sv1},
                  {vecs[i].ready, vecs[i].busy, vecs[i].done, vecs[i].sv});
      checkOutput($sformatf("vecData%0d", i), {dec1, iw1}, {vecs[i].dec, vecs[i].iw});
    end

    // weight_valid low for 5 cycles in FETCH delays done by exactly 5
    start1 = 1'b1; wv1 = 1'b0; fin1 = 32'h3F80_0000; spk1 = 1'b1;
    tick();
    start1 = 1'b0;
    checkOutput("stallFetch", {ready1, idx1, dec1}, {1'b1, 1'b0, 32'h401C28F6});
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("stallHold%0d", i), {ready1, busy1, done1, sv1, idx1, dec1},
                  {5'b11000, 32'h401C28F6});
    end
    wv1 = 1'b1; w1 = 32'h3F80_0000;
    cnt = 5;
    while (!done1 && cnt < 20) begin
      tick();
      cnt++;
    end
    checkOutput("stallLatency", 64'(cnt), 64'd8);
    checkOutput("stallSpike", {sv1, iw1}, {1'b1, 32'h3F80_0000});

    // Full 30-neuron pass with a start pulse in the middle that must be ignored
    start30 = 1'b1; wv30 = 1'b1;
    tick();
    start30 = 1'b0;
    checkOutput("p1First", {ready30, busy30, idx30, dec30}, {2'b11, 5'd0, 32'h0});
    cnt = 0;
    while (!done30 && cnt < 200) begin
      tick();
      cnt++;
      if (cnt == 9) checkOutput("p1Idx3", {ready30, idx30, dec30}, {1'b1, 5'd3, 32'h0});
      if (cnt == 12) checkOutput("p1IgnoreStart", {ready30, busy30, idx30}, {2'b11, 5'd4});
      if (cnt == 45) checkOutput("p1SvStable", {30'h0, sv30}, 60'h0);
      start30 = (cnt == 10);
    end
    start30 = 1'b0;
    checkOutput("p1Latency", 64'(cnt), 64'd90);
    checkOutput("p1SpikeVec", {busy30, sv30}, {1'b0, 30'h15555555});
`ifdef SPIKE_COUNT_EN
    checkOutput("p1SpikeCount", 64'(sc30), 64'd15);
`endif
    tick();

    // Second pass: decayed values of stored potentials, then reset mid-pass
    start30 = 1'b1;
    tick();
    start30 = 1'b0;
    checkOutput("p2Dec0", {idx30, dec30}, {5'd0, 32'h0});
    cnt = 0;
    while (cnt < 16) begin
      tick();
      cnt++;
      if (cnt == 3) checkOutput("p2Dec1", {idx30, dec30}, {5'd1, 32'h3F000000});
    end
    checkOutput("p2SvStable", {busy30, sv30}, {1'b1, 30'h15555555});
    RST_N30 = 1'b0;
    #1;
    checkOutput("midRst", {set30, clr30, ready30, busy30, done30, sv30, idx30}, {5'b01000, 30'h0, 5'd0});
    tick();
    RST_N30 = 1'b1;
    tick();
    checkOutput("midRstInit", {set30, clr30, busy30}, 3'b100);
    tick();
    checkOutput("midRstIdle", {set30, clr30, busy30}, 3'b010);

    // Potentials were cleared by reset, so neuron 1 now decays from zero
    start30 = 1'b1;
    tick();
    start30 = 1'b0;
    repeat (3) tick();
    checkOutput("p3Dec1", {idx30, dec30}, {5'd1, 32'h0});
    cnt = 3;
    while (!done30 && cnt < 200) begin
      tick();
      cnt++;
    end
    checkOutput("p3Latency", 64'(cnt), 64'd90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
